// File: rtl/pattern_pkg.sv
// Shared constants and types for the loopback pattern generator/checker pair:
// comma and error-word encodings, checker states and receive word classes.
package pattern_pkg;

  localparam logic [31:0] K28_5_WORD  = 32'h0000_00BC;
  localparam logic [3:0]  K28_5_KMASK = 4'b0001;
  localparam logic [31:0] ERR_WORD    = 32'hFFFF_FFEF;

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    SYNC   = 2'b01,
    LOCKED = 2'b10
  } chk_state_t;

  typedef enum logic [1:0] {
    WC_COMMA,
    WC_DATA,
    WC_ILLEGAL
  } word_class_t;

  function automatic word_class_t classify(input logic [3:0] k, input logic [31:0] d);
    if (k == K28_5_KMASK && d == K28_5_WORD) return WC_COMMA;
    else if (k == 4'b0000)                   return WC_DATA;
    else                                     return WC_ILLEGAL;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer, async active-low reset to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      meta_q <= 1'b0;
      q_o    <= 1'b0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/pattern_chk.sv
// Receive-side checker for the comma / incrementing-counter loopback stream:
// hunts for the counter, declares lock, then counts mismatching words.
module pattern_chk
  import pattern_pkg::*;
#(
  parameter int g_DATA_WID    = 32,  // classification assumes 32-bit words
  parameter int g_ERR_CNT_WID = 16,
  parameter int g_LOCK_THRESH = 8,
  parameter int g_LOSS_THRESH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     rx_valid_i,
  input  logic [g_DATA_WID-1:0]    data_in_i,
  input  logic [3:0]               rx_k_char_i,
  input  logic                     clear_err_i,
  output logic                     lock_o,
  output logic                     err_o,
  output logic                     err_sticky_o,
  output logic [g_ERR_CNT_WID-1:0] err_cnt_o
);

  localparam logic [7:0]               LOCK_T   = 8'(g_LOCK_THRESH);
  localparam logic [7:0]               LOSS_T   = 8'(g_LOSS_THRESH);
  localparam logic [g_DATA_WID-1:0]    DATA_ONE = g_DATA_WID'(1);
  localparam logic [g_ERR_CNT_WID-1:0] CNT_ONE  = g_ERR_CNT_WID'(1);

  logic clr_s;

  sync_2ff u_clr_sync (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .d_i       (clear_err_i),
    .q_o       (clr_s)
  );

  // Input capture stage; the FSM works on the word registered one edge earlier.
  logic                  rx_valid_q;
  logic [g_DATA_WID-1:0] data_q;
  logic [3:0]            k_q;

  chk_state_t               state_q, state_d;
  logic [g_DATA_WID-1:0]    exp_q, exp_d;
  logic [7:0]               good_q, good_d, bad_q, bad_d;
  logic                     lock_q, lock_d, err_q, err_d, sticky_q, sticky_d;
  logic [g_ERR_CNT_WID-1:0] cnt_q, cnt_d;
  word_class_t              wclass;
  logic                     match, count_err;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rx_valid_q <= 1'b0;
      data_q     <= '0;
      k_q        <= '0;
      state_q    <= HUNT;
      exp_q      <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      lock_q     <= 1'b0;
      err_q      <= 1'b0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      rx_valid_q <= rx_valid_i;
      data_q     <= data_in_i;
      k_q        <= rx_k_char_i;
      state_q    <= state_d;
      exp_q      <= exp_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      lock_q     <= lock_d;
      err_q      <= err_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
    end
  end

  // NOTE: every signal written below gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    good_d    = good_q;
    bad_d     = bad_q;
    lock_d    = lock_q;
    count_err = 1'b0;
    wclass    = classify(k_q, data_q);
    match     = (wclass == WC_DATA) && (data_q == exp_q);

    if (!rx_valid_q) begin
      state_d = HUNT;
      lock_d  = 1'b0;
      good_d  = '0;
      bad_d   = '0;
    end else begin
      case (state_q)
        HUNT: begin
          // Any data word seeds the expectation so we can join a running stream.
          if (wclass == WC_DATA) begin
            exp_d   = data_q + DATA_ONE;
            good_d  = 8'd1;
            state_d = SYNC;
          end
        end
        SYNC: begin
          if (match) begin
            exp_d  = exp_q + DATA_ONE;
            good_d = good_q + 8'd1;
            if (good_q + 8'd1 == LOCK_T) begin
              state_d = LOCKED;
              lock_d  = 1'b1;
              bad_d   = '0;
            end
          end else begin
            state_d = HUNT;
            good_d  = '0;
          end
        end
        LOCKED: begin
          // The generator's error word replaces a count value without stalling it.
          exp_d = exp_q + DATA_ONE;
          if (wclass == WC_COMMA) begin
            state_d = HUNT;
            lock_d  = 1'b0;
            good_d  = '0;
            bad_d   = '0;
          end else if (match) begin
            bad_d = '0;
          end else begin
            count_err = 1'b1;
            bad_d     = bad_q + 8'd1;
            if (bad_q + 8'd1 == LOSS_T) begin
              state_d = HUNT;
              lock_d  = 1'b0;
              good_d  = '0;
              bad_d   = '0;
            end
          end
        end
        default: begin
          state_d = HUNT;
          lock_d  = 1'b0;
          good_d  = '0;
          bad_d   = '0;
        end
      endcase
    end

    // Clear wins over a same-cycle increment; the pulse still reports the word.
    err_d    = count_err;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (clr_s) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end else if (count_err) begin
      sticky_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
    end
  end

  assign lock_o       = lock_q;
  assign err_o        = err_q;
  assign err_sticky_o = sticky_q;
  assign err_cnt_o    = cnt_q;

endmodule

// File: tb/tb_pattern_chk.sv
// Randomised and directed bench for pattern_chk: two instances (16-bit and
// 4-bit error counters) share one stimulus and are checked against a model.
module tb_pattern_chk;
  import pattern_pkg::*;

  localparam int LOCK_T = 8;
  localparam int LOSS_T = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        rx_valid = 1'b0;
  logic        clear_err = 1'b0;
  logic [31:0] data_in = '0;
  logic [3:0]  k_in = '0;
  logic [31:0] tx_cnt = '0;

  logic        lock_a, err_a, sticky_a;
  logic [15:0] cnt_a;
  logic        lock_b, err_b, sticky_b;
  logic [3:0]  cnt_b;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pattern_chk #(.g_DATA_WID(32), .g_ERR_CNT_WID(16), .g_LOCK_THRESH(LOCK_T), .g_LOSS_THRESH(LOSS_T)) dut_a (
    .clk_i(clk), .reset_n_i(reset_n), .rx_valid_i(rx_valid), .data_in_i(data_in),
    .rx_k_char_i(k_in), .clear_err_i(clear_err), .lock_o(lock_a), .err_o(err_a),
    .err_sticky_o(sticky_a), .err_cnt_o(cnt_a));

  pattern_chk #(.g_DATA_WID(32), .g_ERR_CNT_WID(4), .g_LOCK_THRESH(LOCK_T), .g_LOSS_THRESH(LOSS_T)) dut_b (
    .clk_i(clk), .reset_n_i(reset_n), .rx_valid_i(rx_valid), .data_in_i(data_in),
    .rx_k_char_i(k_in), .clear_err_i(clear_err), .lock_o(lock_b), .err_o(err_b),
    .err_sticky_o(sticky_b), .err_cnt_o(cnt_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks "locked" plus run lengths of good/bad words; exp wraps as 32-bit.
  bit          m_lock, m_sticky, m_err;
  int          m_run, m_bad, m_cnt_a, m_cnt_b;
  logic [31:0] m_exp;
  bit          p_v, c1, c2;
  logic [31:0] p_d;
  logic [3:0]  p_k;

  task automatic model_reset();
    m_lock = 0; m_sticky = 0; m_err = 0; m_run = 0; m_bad = 0;
    m_cnt_a = 0; m_cnt_b = 0; m_exp = '0;
    p_v = 0; p_d = '0; p_k = '0; c1 = 0; c2 = 0;
  endtask

  task automatic model_word(input bit v, input logic [3:0] k, input logic [31:0] d, input bit clr);
    bit is_comma, is_data, hit, bad;
    is_comma = (k == 4'b0001) && (d == 32'h0000_00BC);
    is_data  = (k == 4'b0000);
    hit      = is_data && (d == m_exp);
    bad      = 0;
    if (!v) begin
      m_lock = 0; m_run = 0; m_bad = 0;
    end else if (m_lock) begin
      m_exp = m_exp + 1;
      if (is_comma) begin
        m_lock = 0; m_run = 0; m_bad = 0;
      end else if (hit) begin
        m_bad = 0;
      end else begin
        bad = 1;
        m_bad++;
        if (m_bad == LOSS_T) begin m_lock = 0; m_run = 0; m_bad = 0; end
      end
    end else if (m_run == 0) begin
      if (is_data) begin m_exp = d + 1; m_run = 1; end
    end else begin
      if (hit) begin
        m_exp = m_exp + 1;
        m_run++;
        if (m_run == LOCK_T) begin m_lock = 1; m_run = 0; m_bad = 0; end
      end else begin
        m_run = 0;
      end
    end
    m_err = bad;
    if (clr) begin
      m_cnt_a = 0; m_cnt_b = 0; m_sticky = 0;
    end else if (bad) begin
      m_sticky = 1;
      m_cnt_a  = (m_cnt_a < 65535) ? m_cnt_a + 1 : 65535;
      m_cnt_b  = (m_cnt_b < 15) ? m_cnt_b + 1 : 15;
    end
  endtask

  // Word captured at one edge is judged at the next; clear arrives two edges late.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else begin
      model_word(p_v, p_k, p_d, c2);
      c2 = c1; c1 = clear_err;
      p_v = rx_valid; p_d = data_in; p_k = k_in;
    end
  end

  always @(negedge clk) begin
    if (reset_n && chk_en) begin
      check("lock_a", {31'b0, lock_a}, {31'b0, m_lock});
      check("err_a", {31'b0, err_a}, {31'b0, m_err});
      check("sticky_a", {31'b0, sticky_a}, {31'b0, m_sticky});
      check("cnt_a", {16'b0, cnt_a}, m_cnt_a);
      check("lock_b", {31'b0, lock_b}, {31'b0, m_lock});
      check("err_b", {31'b0, err_b}, {31'b0, m_err});
      check("sticky_b", {31'b0, sticky_b}, {31'b0, m_sticky});
      check("cnt_b", {28'b0, cnt_b}, m_cnt_b);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input bit v, input logic [3:0] k, input logic [31:0] d);
    @(negedge clk);
    rx_valid = v; k_in = k; data_in = d;
  endtask
  task automatic send_data(input logic [31:0] d); send(1'b1, 4'b0000, d); endtask
  task automatic send_good(); send_data(tx_cnt); tx_cnt = tx_cnt + 1; endtask
  task automatic send_bad(); send_data(ERR_WORD); tx_cnt = tx_cnt + 1; endtask
  task automatic send_comma(); send(1'b1, K28_5_KMASK, K28_5_WORD); endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    repeat (3) send_good();
    clear_err = 1'b0;
    repeat (3) send_good();
  endtask

  initial begin
    int r;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_lock", {31'b0, lock_a}, 0);
    check("rst_err", {31'b0, err_a}, 0);
    check("rst_sticky", {31'b0, sticky_a}, 0);
    check("rst_cnt", {16'b0, cnt_a}, 0);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Commas, then counter from 1 with one error word in place of 0x20.
    repeat (4) send_comma();
    tx_cnt = 32'd1;
    for (int i = 1; i <= 32'h40; i++) begin
      if (i == 32'h20) send_bad(); else send_good();
      // Outputs seen here reflect word i-2; lock follows seed + 7 matches.
      if (i == 9)  check("lock_low_w7", {31'b0, lock_a}, 0);
      if (i == 10) check("lock_high_w8", {31'b0, lock_a}, 1);
      if (i == 32'h22) check("err_pulse_0x20", {31'b0, err_a}, 1);
      if (i == 32'h23) check("err_single", {31'b0, err_a}, 0);
    end
    check("one_err_cnt", {16'b0, cnt_a}, 1);
    check("one_err_sticky", {31'b0, sticky_a}, 1);
    check("one_err_lock", {31'b0, lock_a}, 1);

    // Four consecutive error words drop lock; the counter resumes and relocks.
    pulse_clear();
    check("cleared_cnt", {16'b0, cnt_a}, 0);
    repeat (4) send_bad();
    send_good(); send_good();
    check("loss_lock", {31'b0, lock_a}, 0);
    check("loss_cnt", {16'b0, cnt_a}, 4);
    repeat (10) send_good();
    check("relock", {31'b0, lock_a}, 1);
    check("relock_cnt", {16'b0, cnt_a}, 4);

    // One invalid cycle, then a comma while locked: both drop lock silently.
    send(1'b0, 4'b0000, 32'h0);
    send_good(); send_good();
    check("invalid_lock", {31'b0, lock_a}, 0);
    check("invalid_cnt", {16'b0, cnt_a}, 4);
    repeat (10) send_good();
    send_comma();
    tx_cnt = 32'd0;
    send_good(); send_good();
    check("comma_lock", {31'b0, lock_a}, 0);
    check("comma_cnt", {16'b0, cnt_a}, 4);

    // Seed just below the wrap and run through 0xFFFFFFFF -> 0.
    send(1'b0, 4'b0000, 32'h0);
    tx_cnt = 32'hFFFF_FFF0;
    while (tx_cnt != 32'h0000_0011) send_good();
    send_good(); send_good();
    check("wrap_lock", {31'b0, lock_a}, 1);
    check("wrap_cnt", {16'b0, cnt_a}, 4);

    // Alternate bad/good: 4-bit counter saturates, lock is held.
    pulse_clear();
    repeat (20) begin send_bad(); send_good(); end
    send_good(); send_good();
    check("sat_cnt_b", {28'b0, cnt_b}, 15);
    check("sat_cnt_a", {16'b0, cnt_a}, 20);
    check("sat_lock", {31'b0, lock_a}, 1);

    // Clear timed to hit the counter on the same edge as an error.
    send_good();
    clear_err = 1'b1;
    send_bad();
    clear_err = 1'b0;
    send_good(); send_good();
    check("clr_err_pulse", {31'b0, err_a}, 1);
    check("clr_err_cnt_a", {16'b0, cnt_a}, 0);
    check("clr_err_cnt_b", {28'b0, cnt_b}, 0);
    check("clr_err_sticky", {31'b0, sticky_a}, 0);

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      r = $urandom_range(0, 99);
      clear_err = ($urandom_range(0, 99) < 3);
      if (r < 86)      send_good();
      else if (r < 90) send_bad();
      else if (r < 92) begin send_comma(); tx_cnt = $urandom; end
      else if (r < 94) send(1'b1, 4'($urandom_range(2, 15)), $urandom);
      else if (r < 96) send(1'b0, 4'($urandom), $urandom);
      else begin send_data($urandom); tx_cnt = tx_cnt + 1; end
    end
    clear_err = 1'b0;

    // Reset in the middle of lock clears outputs immediately.
    send(1'b0, 4'b0000, 32'h0);
    repeat (12) send_good();
    check("pre_rst_lock", {31'b0, lock_a}, 1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_lock", {31'b0, lock_a}, 0);
    check("midrst_err", {31'b0, err_a}, 0);
    check("midrst_sticky", {31'b0, sticky_a}, 0);
    check("midrst_cnt", {16'b0, cnt_a}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) send_comma();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
